// File: rtl/rsa_modexp.sv
// Memory-mapped Montgomery modular-exponentiation engine with a bit-serial
// radix-2 Montgomery multiplier and word-indexed operand access.
module rsa_modexp #(
    parameter int KEY_WIDTH = 64
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic        bus_write_en,
    input  logic        bus_read_en,
    input  logic        RSA_ENABLE,
    input  logic [7:0]  bus_addr,
    input  logic [31:0] bus_write_data,
    output logic [31:0] bus_read_data,
    output logic        result_valid,
    output logic        busy,
    output logic        irq
);
    localparam int NW = KEY_WIDTH / 32;
    localparam int CW = $clog2(KEY_WIDTH + 2);
    localparam int EW = $clog2(KEY_WIDTH);

    localparam logic [7:0] ADDR_WSEL   = 8'h08;
    localparam logic [7:0] ADDR_MSG    = 8'h0C;
    localparam logic [7:0] ADDR_MOD    = 8'h10;
    localparam logic [7:0] ADDR_EXP    = 8'h14;
    localparam logic [7:0] ADDR_RR     = 8'h18;
    localparam logic [7:0] ADDR_CTRL   = 8'h1C;
    localparam logic [7:0] ADDR_RESULT = 8'h20;
    localparam logic [7:0] ADDR_STATUS = 8'h24;
    localparam logic [7:0] ADDR_EBITS  = 8'h28;

    typedef enum logic [2:0] {
        S_IDLE, S_INIT_X, S_INIT_Z, S_MULT, S_SQR, S_FINAL, S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [KEY_WIDTH-1:0] msg_q, msg_d, mod_q, mod_d, exp_q, exp_d, rr_q, rr_d;
    logic [KEY_WIDTH-1:0] res_q, res_d, x_q, x_d, z_q, z_d, a_q, a_d, b_q, b_d;
    logic [KEY_WIDTH+1:0] p_q, p_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [EW-1:0]        i_q, i_d;
    logic [31:0]          exp_bits_q, exp_bits_d;
    logic [7:0]           idx_q, idx_d;
    logic                 auto_q, auto_d, irq_en_q, irq_en_d;
    logic                 valid_q, valid_d, busy_q, busy_d, error_q, error_d, irq_q;

    logic                 wr, rd, idx_ok, oper_wr, ctrl_wr, abort, start, start_bad, res_rd;
    logic [EW-1:0]        i_nxt;
    logic                 last_cur, last_nxt;
    logic [KEY_WIDTH+1:0] m_ext, t_add, t_red, p_iter;
    logic [KEY_WIDTH-1:0] mm_out;

    function automatic logic [KEY_WIDTH-1:0] put_word(input logic [KEY_WIDTH-1:0] v,
                                                      input logic [7:0] idx,
                                                      input logic [31:0] d);
        put_word = v;
        for (int w = 0; w < NW; w++)
            if (idx == 8'(w)) put_word[w*32 +: 32] = d;
    endfunction

    function automatic logic [31:0] get_word(input logic [KEY_WIDTH-1:0] v,
                                             input logic [7:0] idx);
        get_word = '0;
        for (int w = 0; w < NW; w++)
            if (idx == 8'(w)) get_word = v[w*32 +: 32];
    endfunction

    assign wr        = bus_write_en & RSA_ENABLE;
    assign rd        = bus_read_en & RSA_ENABLE;
    assign idx_ok    = idx_q < 8'(NW);
    assign oper_wr   = wr & ~busy_q & idx_ok &
                       (bus_addr == ADDR_MSG || bus_addr == ADDR_MOD ||
                        bus_addr == ADDR_EXP || bus_addr == ADDR_RR);
    assign ctrl_wr   = wr & (bus_addr == ADDR_CTRL);
    assign abort     = ctrl_wr & bus_write_data[1];
    assign start     = ctrl_wr & bus_write_data[0] & ~bus_write_data[1] & ~busy_q;
    assign start_bad = ~mod_q[0] | (exp_bits_q == 32'd0) | (exp_bits_q > 32'(KEY_WIDTH));
    assign res_rd    = rd & (bus_addr == ADDR_RESULT) & idx_ok;

    assign i_nxt    = i_q + 1'b1;
    assign last_cur = (32'(i_q) == exp_bits_q - 32'd1);
    assign last_nxt = (32'(i_nxt) == exp_bits_q - 32'd1);

    // One Montgomery iteration: add A[j]*B, make even with M, halve.
    // P stays below 2M, so KEY_WIDTH+2 bits never overflow.
    assign m_ext  = {2'b00, mod_q};
    assign t_add  = p_q + (a_q[0] ? {2'b00, b_q} : '0);
    assign t_red  = t_add[0] ? t_add + m_ext : t_add;
    assign p_iter = t_red >> 1;
    assign mm_out = KEY_WIDTH'((p_q >= m_ext) ? p_q - m_ext : p_q);

    always_comb begin
        state_d    = state_q;
        msg_d      = msg_q;
        mod_d      = mod_q;
        exp_d      = exp_q;
        rr_d       = rr_q;
        res_d      = res_q;
        x_d        = x_q;
        z_d        = z_q;
        a_d        = a_q;
        b_d        = b_q;
        p_d        = p_q;
        cnt_d      = cnt_q;
        i_d        = i_q;
        exp_bits_d = exp_bits_q;
        idx_d      = idx_q;
        auto_d     = auto_q;
        irq_en_d   = irq_en_q;
        valid_d    = valid_q;
        busy_d     = busy_q;
        error_d    = error_q;

        if (wr) begin
            case (bus_addr)
                ADDR_WSEL: begin
                    idx_d  = bus_write_data[7:0];
                    auto_d = bus_write_data[8];
                end
                ADDR_MSG: if (oper_wr) msg_d = put_word(msg_q, idx_q, bus_write_data);
                ADDR_MOD: if (oper_wr) mod_d = put_word(mod_q, idx_q, bus_write_data);
                ADDR_EXP: if (oper_wr) exp_d = put_word(exp_q, idx_q, bus_write_data);
                ADDR_RR:  if (oper_wr) rr_d  = put_word(rr_q, idx_q, bus_write_data);
                ADDR_CTRL:   irq_en_d = bus_write_data[2];
                ADDR_STATUS: if (bus_write_data[0]) valid_d = 1'b0;
                ADDR_EBITS:  if (!busy_q) exp_bits_d = bus_write_data;
                default: ;
            endcase
        end
        if ((oper_wr || res_rd) && auto_q)
            idx_d = idx_q + 8'd1;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    valid_d = 1'b0;
                    if (start_bad) begin
                        error_d = 1'b1;
                    end else begin
                        error_d = 1'b0;
                        busy_d  = 1'b1;
                        state_d = S_INIT_X;
                        cnt_d   = '0;
                        i_d     = '0;
                    end
                end
            end
            S_INIT_X, S_INIT_Z, S_MULT, S_SQR, S_FINAL: begin
                if (cnt_q == '0) begin
                    p_d   = '0;
                    cnt_d = cnt_q + 1'b1;
                    case (state_q)
                        S_INIT_X: begin a_d = KEY_WIDTH'(1); b_d = rr_q; end
                        S_INIT_Z: begin a_d = msg_q;         b_d = rr_q; end
                        S_MULT:   begin a_d = x_q;           b_d = z_q;  end
                        S_SQR:    begin a_d = z_q;           b_d = z_q;  end
                        default:  begin a_d = x_q;           b_d = KEY_WIDTH'(1); end
                    endcase
                end else if (cnt_q <= CW'(KEY_WIDTH)) begin
                    p_d   = p_iter;
                    a_d   = a_q >> 1;
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d = '0;
                    case (state_q)
                        S_INIT_X: begin
                            x_d     = mm_out;
                            state_d = S_INIT_Z;
                        end
                        S_INIT_Z: begin
                            z_d     = mm_out;
                            state_d = exp_q[i_q] ? S_MULT : (last_cur ? S_FINAL : S_SQR);
                        end
                        S_MULT: begin
                            x_d     = mm_out;
                            state_d = last_cur ? S_FINAL : S_SQR;
                        end
                        S_SQR: begin
                            z_d     = mm_out;
                            i_d     = i_nxt;
                            state_d = exp_q[i_nxt] ? S_MULT : (last_nxt ? S_FINAL : S_SQR);
                        end
                        default: begin
                            x_d     = mm_out;
                            state_d = S_DONE;
                        end
                    endcase
                end
            end
            S_DONE: begin
                res_d   = x_q;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything, including a completion in the same cycle.
        if (abort) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            valid_d = 1'b0;
            res_d   = res_q;
        end
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            msg_q      <= '0;
            mod_q      <= '0;
            exp_q      <= '0;
            rr_q       <= '0;
            res_q      <= '0;
            x_q        <= '0;
            z_q        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            p_q        <= '0;
            cnt_q      <= '0;
            i_q        <= '0;
            exp_bits_q <= '0;
            idx_q      <= '0;
            auto_q     <= 1'b0;
            irq_en_q   <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            error_q    <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            msg_q      <= msg_d;
            mod_q      <= mod_d;
            exp_q      <= exp_d;
            rr_q       <= rr_d;
            res_q      <= res_d;
            x_q        <= x_d;
            z_q        <= z_d;
            a_q        <= a_d;
            b_q        <= b_d;
            p_q        <= p_d;
            cnt_q      <= cnt_d;
            i_q        <= i_d;
            exp_bits_q <= exp_bits_d;
            idx_q      <= idx_d;
            auto_q     <= auto_d;
            irq_en_q   <= irq_en_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            error_q    <= error_d;
            irq_q      <= valid_d & irq_en_d;
        end
    end

    always_comb begin
        bus_read_data = '0;
        if (rd) begin
            case (bus_addr)
                ADDR_WSEL:   bus_read_data = {23'd0, auto_q, idx_q};
                ADDR_MSG:    bus_read_data = get_word(msg_q, idx_q);
                ADDR_MOD:    bus_read_data = get_word(mod_q, idx_q);
                ADDR_EXP:    bus_read_data = get_word(exp_q, idx_q);
                ADDR_RR:     bus_read_data = get_word(rr_q, idx_q);
                ADDR_CTRL:   bus_read_data = {29'd0, irq_en_q, 2'b00};
                ADDR_RESULT: bus_read_data = get_word(res_q, idx_q);
                ADDR_STATUS: bus_read_data = {29'd0, error_q, busy_q, valid_q};
                ADDR_EBITS:  bus_read_data = exp_bits_q;
                default:     bus_read_data = '0;
            endcase
        end
    end

    assign result_valid = valid_q;
    assign busy         = busy_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_rsa_modexp.sv
// Directed bench for rsa_modexp: a 64-bit and a 128-bit instance share one
// bus and are selected through their RSA_ENABLE inputs.
module tb_rsa_modexp;
    logic        pclk = 1'b0;
    logic        reset;
    logic        bus_write_en, bus_read_en, en64, en128;
    logic [7:0]  bus_addr;
    logic [31:0] bus_write_data;
    logic [31:0] rdata64, rdata128;
    logic        valid64, busy64, irq64, valid128, busy128, irq128;

    int          nAsserts = 0;
    int          nFail = 0;
    bit          use128 = 1'b0;

    localparam logic [63:0]  M64  = 64'hFFFFFFFFFFFFFFC5;
    localparam logic [127:0] M128 = 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF61;

    rsa_modexp #(.KEY_WIDTH(64)) dut64 (
        .pclk(pclk), .reset(reset), .bus_write_en(bus_write_en), .bus_read_en(bus_read_en),
        .RSA_ENABLE(en64), .bus_addr(bus_addr), .bus_write_data(bus_write_data),
        .bus_read_data(rdata64), .result_valid(valid64), .busy(busy64), .irq(irq64)
    );

    rsa_modexp #(.KEY_WIDTH(128)) dut128 (
        .pclk(pclk), .reset(reset), .bus_write_en(bus_write_en), .bus_read_en(bus_read_en),
        .RSA_ENABLE(en128), .bus_addr(bus_addr), .bus_write_data(bus_write_data),
        .bus_read_data(rdata128), .result_valid(valid128), .busy(busy128), .irq(irq128)
    );

    always #5 pclk = ~pclk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        nAsserts++;
        assert (observed === expected)
        else begin
            nFail++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] addr, input logic [31:0] data);
        bus_addr       = addr;
        bus_write_data = data;
        bus_write_en   = 1'b1;
        @(posedge pclk);
        #1;
        bus_write_en   = 1'b0;
    endtask

    task automatic readReg(input logic [7:0] addr, output logic [31:0] data);
        bus_addr    = addr;
        bus_read_en = 1'b1;
        #1;
        data = use128 ? rdata128 : rdata64;
        @(posedge pclk);
        #1;
        bus_read_en = 1'b0;
    endtask

    task automatic readResult(input logic [7:0] idx, output logic [31:0] data);
        applyStimulus(8'h08, {24'd0, idx});
        readReg(8'h20, data);
    endtask

    task automatic loadOperands(input int nw, input logic [127:0] msg, mdl, ex, rr,
                                input logic [31:0] ebits);
        applyStimulus(8'h08, 32'h100);
        for (int w = 0; w < nw; w++) applyStimulus(8'h0C, msg[w*32 +: 32]);
        applyStimulus(8'h08, 32'h100);
        for (int w = 0; w < nw; w++) applyStimulus(8'h10, mdl[w*32 +: 32]);
        applyStimulus(8'h08, 32'h100);
        for (int w = 0; w < nw; w++) applyStimulus(8'h14, ex[w*32 +: 32]);
        applyStimulus(8'h08, 32'h100);
        for (int w = 0; w < nw; w++) applyStimulus(8'h18, rr[w*32 +: 32]);
        applyStimulus(8'h28, ebits);
        applyStimulus(8'h08, 32'h0);
    endtask

    task automatic waitValid(output int cycles);
        cycles = 0;
        while (!(use128 ? valid128 : valid64) && cycles < 3000) begin
            @(posedge pclk);
            #1;
            cycles++;
        end
    endtask

    initial begin
        logic [31:0] d;
        int          cyc;

        reset = 1'b1;
        bus_write_en = 1'b0;
        bus_read_en = 1'b0;
        bus_addr = 8'h00;
        bus_write_data = 32'h0;
        en64 = 1'b1;
        en128 = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
        checkOutput("rst_busy", 64'(busy64), 64'd0);
        checkOutput("rst_valid", 64'(valid64), 64'd0);
        checkOutput("rst_irq", 64'(irq64), 64'd0);
        checkOutput("rst_rdata", 64'(rdata64), 64'd0);
        reset = 1'b0;
        @(posedge pclk);
        #1;

        $display("[TB] test 1: 2^10 mod M64");
        loadOperands(2, 128'h2, 128'(M64), 128'd10, 128'hD99, 32'd4);
        applyStimulus(8'h1C, 32'h1);
        checkOutput("t1_busy_start", 64'(busy64), 64'd1);
        waitValid(cyc);
        checkOutput("t1_latency", 64'(cyc), 64'd529);
        checkOutput("t1_busy_done", 64'(busy64), 64'd0);
        readResult(8'd0, d);
        checkOutput("t1_res_w0", 64'(d), 64'h400);
        readResult(8'd1, d);
        checkOutput("t1_res_w1", 64'(d), 64'h0);
        readReg(8'h24, d);
        checkOutput("t1_status", 64'(d), 64'h1);

        $display("[TB] test 2: (M-1)^3 with interrupt");
        loadOperands(2, 128'hFFFFFFFFFFFFFFC4, 128'(M64), 128'd3, 128'hD99, 32'd2);
        applyStimulus(8'h1C, 32'h5);
        waitValid(cyc);
        checkOutput("t2_latency", 64'(cyc), 64'd397);
        checkOutput("t2_irq", 64'(irq64), 64'd1);
        readResult(8'd0, d);
        checkOutput("t2_res_w0", 64'(d), 64'hFFFFFFC4);
        readResult(8'd1, d);
        checkOutput("t2_res_w1", 64'(d), 64'hFFFFFFFF);
        applyStimulus(8'h24, 32'h1);
        checkOutput("t2_clr_valid", 64'(valid64), 64'd0);
        checkOutput("t2_clr_irq", 64'(irq64), 64'd0);

        $display("[TB] test 4: start errors and out-of-range index");
        loadOperands(2, 128'h2, 128'hFFFFFFFFFFFFFFC4, 128'd10, 128'hD99, 32'd4);
        applyStimulus(8'h1C, 32'h1);
        checkOutput("t4_even_busy", 64'(busy64), 64'd0);
        repeat (20) @(posedge pclk);
        #1;
        readReg(8'h24, d);
        checkOutput("t4_even_status", 64'(d), 64'h4);
        loadOperands(2, 128'h2, 128'(M64), 128'd10, 128'hD99, 32'd0);
        applyStimulus(8'h1C, 32'h1);
        readReg(8'h24, d);
        checkOutput("t4_eb0_status", 64'(d), 64'h4);
        applyStimulus(8'h28, 32'd65);
        applyStimulus(8'h1C, 32'h1);
        readReg(8'h24, d);
        checkOutput("t4_eb65_status", 64'(d), 64'h4);
        readResult(8'd2, d);
        checkOutput("t4_idx_nw", 64'(d), 64'h0);

        $display("[TB] test 5: abort and busy write protection");
        loadOperands(2, 128'h2, 128'(M64), 128'd10, 128'hD99, 32'd4);
        applyStimulus(8'h1C, 32'h1);
        repeat (99) @(posedge pclk);
        #1;
        applyStimulus(8'h1C, 32'h2);
        checkOutput("t5_abort_busy", 64'(busy64), 64'd0);
        checkOutput("t5_abort_valid", 64'(valid64), 64'd0);
        readReg(8'h24, d);
        checkOutput("t5_abort_status", 64'(d), 64'h0);
        readResult(8'd0, d);
        checkOutput("t5_res_kept", 64'(d), 64'hFFFFFFC4);
        applyStimulus(8'h1C, 32'h3);
        checkOutput("t5_abort_start", 64'(busy64), 64'd0);
        applyStimulus(8'h1C, 32'h1);
        repeat (10) @(posedge pclk);
        #1;
        applyStimulus(8'h0C, 32'h5);
        waitValid(cyc);
        checkOutput("t5_latency", 64'(cyc), 64'd518);
        readResult(8'd0, d);
        checkOutput("t5_res_w0", 64'(d), 64'h400);

        $display("[TB] test 6: reset mid-operation");
        loadOperands(2, 128'h2, 128'(M64), 128'd10, 128'hD99, 32'd4);
        applyStimulus(8'h1C, 32'h1);
        repeat (200) @(posedge pclk);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("t6_rst_busy", 64'(busy64), 64'd0);
        checkOutput("t6_rst_valid", 64'(valid64), 64'd0);
        checkOutput("t6_rst_irq", 64'(irq64), 64'd0);
        @(posedge pclk);
        #1;
        reset = 1'b0;
        readReg(8'h28, d);
        checkOutput("t6_ebits_cleared", 64'(d), 64'h0);
        loadOperands(2, 128'h2, 128'(M64), 128'd10, 128'hD99, 32'd4);
        applyStimulus(8'h1C, 32'h1);
        waitValid(cyc);
        checkOutput("t6_latency", 64'(cyc), 64'd529);
        readResult(8'd0, d);
        checkOutput("t6_res_w0", 64'(d), 64'h400);

        $display("[TB] test 3: 128-bit 2^100 with auto-increment");
        en64 = 1'b0;
        en128 = 1'b1;
        use128 = 1'b1;
        loadOperands(4, 128'h2, M128, 128'd100, 128'h62C1, 32'd7);
        applyStimulus(8'h1C, 32'h1);
        waitValid(cyc);
        checkOutput("t3_latency", 64'(cyc), 64'd1561);
        applyStimulus(8'h08, 32'h100);
        readReg(8'h20, d);
        checkOutput("t3_res_w0", 64'(d), 64'h0);
        readReg(8'h20, d);
        checkOutput("t3_res_w1", 64'(d), 64'h0);
        readReg(8'h20, d);
        checkOutput("t3_res_w2", 64'(d), 64'h0);
        readReg(8'h20, d);
        checkOutput("t3_res_w3", 64'(d), 64'h10);
        readReg(8'h08, d);
        checkOutput("t3_wsel_after", 64'(d), 64'h104);
        bus_addr = 8'h24;
        bus_read_en = 1'b1;
        #1;
        checkOutput("t3_disabled_rdata", 64'(rdata64), 64'h0);
        checkOutput("t3_status128", 64'(rdata128), 64'h1);
        @(posedge pclk);
        #1;
        bus_read_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end
endmodule
